// File: rtl/count_sequencer.sv
// Run/pause/idle sequencer driving a bounded up/down counter from a
// rate-selectable prescaler; tick and wrap are single-cycle pulses.
module count_sequencer #(
  parameter int BASE_TICKS = 25000000,
  parameter int PRE_W      = 28,
  parameter int WIDTH      = 4,
  parameter int MAX_VAL    = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [1:0]       rate_sel,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             wrap,
  output logic             running,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } state_t;

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [PRE_W-1:0] BASE = PRE_W'(BASE_TICKS);

  state_t           cur;
  state_t           nxt;
  logic [PRE_W-1:0] pre;
  logic [PRE_W-1:0] thresh;
  logic [1:0]       activeSel;
  logic [WIDTH-1:0] nextCount;
  logic [WIDTH-1:0] loadClamp;
  logic             runEdge;
  logic             tickEdge;
  logic             atWrap;

  assign thresh    = BASE << activeSel;
  assign runEdge   = (cur == RUN) && !clear && !stop;
  assign tickEdge  = runEdge && (pre == thresh - PRE_W'(1));
  assign loadClamp = (load_val > MAXV) ? MAXV : load_val;
  assign atWrap    = dir ? (count == MAXV) : (count == '0);

  always_comb begin
    nextCount = count;
    unique case (1'b1)
      dir && atWrap:   nextCount = '0;
      dir && !atWrap:  nextCount = count + WIDTH'(1);
      !dir && atWrap:  nextCount = MAXV;
      default:         nextCount = count - WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) cur <= IDLE;
    else     cur <= nxt;
  end

  // load blocks start in IDLE/PAUSE; in RUN load is simply not seen
  always_comb begin
    nxt = cur;
    case (cur)
      IDLE, PAUSE: begin
        if (clear)               nxt = IDLE;
        else if (!load && start) nxt = RUN;
      end
      RUN: begin
        if (clear)      nxt = IDLE;
        else if (stop)  nxt = PAUSE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    running = (cur == RUN);
    state   = cur;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      pre       <= '0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
      activeSel <= 2'b00;
    end else begin
      tick <= tickEdge;
      wrap <= tickEdge && atWrap;
      if (cur == IDLE || tickEdge) activeSel <= rate_sel;
      if (clear) begin
        count <= '0;
        pre   <= '0;
      end else if (load && cur != RUN) begin
        count <= loadClamp;
      end else if (runEdge) begin
        if (tickEdge) begin
          pre   <= '0;
          count <= nextCount;
        end else begin
          pre <= pre + PRE_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: vector table, directed corner sequences,
// then random stimulus against a period/elapsed-time reference model.
module tb_count_sequencer;

  localparam int BT = 4;
  localparam int PW = 8;
  localparam int W  = 4;
  localparam int MV = 9;

  logic         clk = 1'b0;
  logic         rst, start, stop, clear, load, dir;
  logic [W-1:0] load_val;
  logic [1:0]   rate_sel;
  logic [W-1:0] count;
  logic         tick, wrap, running;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  count_sequencer #(
    .BASE_TICKS(BT), .PRE_W(PW), .WIDTH(W), .MAX_VAL(MV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .clear(clear), .load(load), .load_val(load_val),
    .dir(dir), .rate_sel(rate_sel), .count(count),
    .tick(tick), .wrap(wrap), .running(running), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r, s, p, c, l, lv, d, sel;
    int eCount, eTick, eWrap, eState;
  } vec_t;

  // model: 0 idle, 1 run, 2 pause; mEl = run edges into current period
  int mState, mCount, mEl, mSel, mTick, mWrap;

  task automatic chkOut(input string name, input int eC, input int eT,
                        input int eW, input int eS);
    checks++;
    if (count !== 4'(eC) || tick !== (eT != 0) || wrap !== (eW != 0) ||
        state !== 2'(eS) || running !== (eS == 1)) begin
      errors++;
      $display("FAIL %s: count=%0d tick=%b wrap=%b state=%0d run=%b; want count=%0d tick=%0d wrap=%0d state=%0d",
               name, count, tick, wrap, state, running, eC, eT, eW, eS);
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic apply(input int r, input int s, input int p, input int c,
                       input int l, input int lv, input int d, input int sel);
    rst      = (r != 0);
    start    = (s != 0);
    stop     = (p != 0);
    clear    = (c != 0);
    load     = (l != 0);
    load_val = 4'(lv);
    dir      = (d != 0);
    rate_sel = 2'(sel);
  endtask

  task automatic edgeClk;
    @(posedge clk);
    #1;
  endtask

  task automatic runToTick(input int expGap, input string name);
    int n;
    n = 0;
    do begin
      edgeClk();
      n++;
    end while (!tick && n < 80);
    chk(name, n, expGap);
  endtask

  task automatic modelStep(input vec_t v);
    int period;
    int wasIdle;
    period  = BT << mSel;
    wasIdle = int'(mState == 0);
    mTick = 0;
    mWrap = 0;
    if (v.r != 0) begin
      mState = 0; mCount = 0; mEl = 0; mSel = 0;
      return;
    end
    if (v.c != 0) begin
      mState = 0; mCount = 0; mEl = 0;
    end else if (v.l != 0 && mState != 1) begin
      mCount = (v.lv > MV) ? MV : v.lv;
    end else if (mState == 1) begin
      if (v.p != 0) mState = 2;
      else begin
        mEl++;
        if (mEl == period) begin
          mEl = 0;
          mTick = 1;
          if (v.d != 0) begin
            mWrap  = int'(mCount == MV);
            mCount = (mCount + 1) % (MV + 1);
          end else begin
            mWrap  = int'(mCount == 0);
            mCount = (mCount + MV) % (MV + 1);
          end
        end
      end
    end else if (v.s != 0) begin
      mState = 1;
    end
    if (wasIdle != 0 || mTick != 0) mSel = v.sel;
  endtask

  vec_t tbl [15];
  vec_t v;
  int   rSel, rDir;

  initial begin
    //          r s p c l lv d sel  cnt t w st
    tbl[0]  = '{1,0,0,0,0, 0,1,0,   0,0,0,0};
    tbl[1]  = '{0,0,0,0,1,12,1,0,   9,0,0,0};
    tbl[2]  = '{0,0,0,0,1, 5,1,0,   5,0,0,0};
    tbl[3]  = '{0,1,0,0,1, 3,1,0,   3,0,0,0};
    tbl[4]  = '{0,1,0,0,0, 0,1,0,   3,0,0,1};
    tbl[5]  = '{0,0,0,0,1, 7,1,0,   3,0,0,1};
    tbl[6]  = '{0,0,1,0,0, 0,1,0,   3,0,0,2};
    tbl[7]  = '{0,0,1,0,0, 0,1,0,   3,0,0,2};
    tbl[8]  = '{0,0,0,0,1, 8,1,0,   8,0,0,2};
    tbl[9]  = '{0,1,0,0,0, 0,1,0,   8,0,0,1};
    tbl[10] = '{0,0,0,0,0, 0,1,0,   8,0,0,1};
    tbl[11] = '{0,0,0,0,0, 0,1,0,   8,0,0,1};
    tbl[12] = '{0,0,0,0,0, 0,1,0,   9,1,0,1};
    tbl[13] = '{0,0,0,1,1, 4,1,0,   0,0,0,0};
    tbl[14] = '{1,1,0,0,0, 0,1,0,   0,0,0,0};

    apply(1, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].r, tbl[i].s, tbl[i].p, tbl[i].c, tbl[i].l,
            tbl[i].lv, tbl[i].d, tbl[i].sel);
      edgeClk();
      chkOut($sformatf("vec%0d", i), tbl[i].eCount, tbl[i].eTick,
             tbl[i].eWrap, tbl[i].eState);
    end

    // up count through a full wrap
    apply(1, 0, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r37 reset", 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r37 start", 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 10; k++) begin
      runToTick(4, "r37 gap");
      chkOut("r37 tick", k % 10, 1, int'(k == 10), 1);
    end

    // rate change mid-period does not disturb the current period
    edgeClk(); edgeClk();
    apply(0, 0, 0, 0, 0, 0, 1, 2);
    runToTick(2, "r38 old period");
    runToTick(16, "r38 new period a");
    runToTick(16, "r38 new period b");

    // pause keeps the partial period
    apply(1, 0, 0, 0, 0, 0, 1, 0); edgeClk();
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    apply(0, 0, 0, 0, 0, 0, 1, 0); edgeClk(); edgeClk();
    apply(0, 0, 1, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r39 paused", 0, 0, 0, 2);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 10; k++) begin
      edgeClk();
      chkOut("r39 hold", 0, 0, 0, 2);
    end
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r39 resume", 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    runToTick(2, "r39 gap");
    chkOut("r39 tick", 1, 1, 0, 1);

    // clamped load in pause, then count down through wrap
    apply(0, 0, 1, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r40 pause", 1, 0, 0, 2);
    apply(0, 0, 0, 0, 1, 12, 1, 0); edgeClk();
    chkOut("r40 load", 9, 0, 0, 2);
    apply(0, 1, 0, 0, 0, 0, 0, 0); edgeClk();
    chkOut("r40 start", 9, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      runToTick(4, "r40 gap");
      chkOut("r40 tick", (k == 10) ? 9 : 9 - k, 1, int'(k == 10), 1);
    end

    // load ignored in RUN; clear beats start on a terminal edge
    apply(1, 0, 0, 0, 0, 0, 1, 0); edgeClk();
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) runToTick(4, "r41 gap");
    apply(0, 0, 0, 0, 1, 2, 1, 0); edgeClk();
    chkOut("r41 load ignored", 5, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 1, 0); edgeClk(); edgeClk();
    apply(0, 1, 0, 1, 0, 0, 1, 0); edgeClk();
    chkOut("r41 clear", 0, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r41 idle", 0, 0, 0, 0);

    // reset mid-period discards the partial period
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    apply(0, 0, 0, 0, 0, 0, 1, 0); edgeClk(); edgeClk(); edgeClk();
    apply(1, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r42 reset", 0, 0, 0, 0);
    apply(0, 1, 0, 0, 0, 0, 1, 0); edgeClk();
    chkOut("r42 start", 0, 0, 0, 1);
    apply(0, 0, 0, 0, 0, 0, 1, 0);
    runToTick(4, "r42 gap");
    chkOut("r42 tick", 1, 1, 0, 1);

    // random stimulus against the reference model
    rSel = 0;
    rDir = 1;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) rSel = int'($urandom_range(0, 3));
      if ($urandom_range(0, 19) == 0) rDir = int'($urandom_range(0, 1));
      v.r   = int'(i == 0 || $urandom_range(0, 299) == 0);
      v.s   = int'($urandom_range(0, 5) == 0);
      v.p   = int'($urandom_range(0, 14) == 0);
      v.c   = int'($urandom_range(0, 59) == 0);
      v.l   = int'($urandom_range(0, 11) == 0);
      v.lv  = int'($urandom_range(0, 15));
      v.d   = rDir;
      v.sel = rSel;
      apply(v.r, v.s, v.p, v.c, v.l, v.lv, v.d, v.sel);
      edgeClk();
      modelStep(v);
      chkOut($sformatf("rand%0d", i), mCount, mTick, mWrap, mState);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_sequencer.md
COUNT_SEQUENCER -- requirements
Module: count_sequencer

Interface
REQ-001 SHALL have parameter BASE_TICKS, default 25000000, clk cycles per tick at rate_sel=00 (0.5 s at 50 MHz).
REQ-002 SHALL have parameter PRE_W, default 28, prescaler width; must satisfy 8*BASE_TICKS < 2^PRE_W.
REQ-003 SHALL have parameter WIDTH, default 4, count width.
REQ-004 SHALL have parameter MAX_VAL, default 9, largest count value; must satisfy MAX_VAL < 2^WIDTH.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port start  input  1  level; run request.
REQ-008 SHALL have port stop  input  1  level; pause request.
REQ-009 SHALL have port clear  input  1  level; return to IDLE with count zeroed.
REQ-010 SHALL have port load  input  1  level; load load_val into count.
REQ-011 SHALL have port load_val  input  WIDTH  value for load.
REQ-012 SHALL have port dir  input  1  1 = count up, 0 = count down.
REQ-013 SHALL have port rate_sel  input  2  tick period select.
REQ-014 SHALL have port count  output  WIDTH  current count value, registered.
REQ-015 SHALL have port tick  output  1  one-cycle pulse per period, registered.
REQ-016 SHALL have port wrap  output  1  one-cycle pulse on count wrap, registered.
REQ-017 SHALL have port running  output  1  high when state is RUN.
REQ-018 SHALL have port state  output  2  IDLE=00, RUN=01, PAUSE=10; 11 unused.

Function
REQ-019 SHALL define thresh = BASE_TICKS << active_sel: 00 gives x1, 01 gives x2, 10 gives x4, 11 gives x8.
REQ-020 SHALL latch active_sel from rate_sel in IDLE every cycle and in RUN only on a tick edge; rate_sel changes mid-period SHALL NOT truncate or extend the current period.
REQ-021 SHALL apply per-edge priority rst > clear > load > stop > start.
REQ-022 SHALL, on clear from any state, go to IDLE with count=0 and prescaler=0.
REQ-023 SHALL, on start in IDLE or PAUSE, go to RUN; SHALL ignore start while in RUN.
REQ-024 SHALL, on stop in RUN, go to PAUSE; SHALL ignore stop while in IDLE or PAUSE.
REQ-025 SHALL, on load in IDLE or PAUSE, set count=min(load_val, MAX_VAL) with no state change; SHALL ignore load while in RUN.
REQ-026 SHALL advance the prescaler only in RUN on edges without stop asserted; it holds in PAUSE, so a resume continues the partial period.
REQ-027 SHALL, when the prescaler equals thresh-1 on a RUN edge, reset the prescaler to 0, set tick=1 for one cycle, and update count on the same edge.
REQ-028 SHALL, when counting up: if count==MAX_VAL, set count to 0 and wrap=1; otherwise increment count.
REQ-029 SHALL, when counting down: if count==0, set count to MAX_VAL and wrap=1; otherwise decrement count.
REQ-030 SHALL sample dir only on the tick edge.
REQ-031 SHALL, when stop coincides with the terminal prescaler value, not tick; state goes to PAUSE and the prescaler holds at thresh-1, so the tick fires on the first RUN edge after resume.
REQ-032 SHALL produce the first tick on the thresh-th edge after the edge that samples start from IDLE.
REQ-033 SHALL keep tick and wrap low in every cycle except the tick edge.
REQ-034 SHALL never present a count value greater than MAX_VAL.

Reset
REQ-035 SHALL, when rst is sampled high, set state=IDLE, count=0, tick=0, wrap=0, running=0, prescaler=0, active_sel=00, regardless of other inputs or current state.
REQ-036 SHALL, if rst is asserted mid-period in RUN, discard the partial period; after release, the next start gives a full thresh period.

Verification (BASE_TICKS=4, MAX_VAL=9, WIDTH=4)
REQ-037 SHALL verify: rst, then a 1-cycle start with rate_sel=00, dir=1 -> tick pulses every 4 cycles; count goes 1..9, then 0 with wrap=1 on the 10th tick.
REQ-038 SHALL verify: rate_sel 00->10 two cycles after a tick -> next tick still 4 cycles after the previous one, then ticks every 16 cycles.
REQ-039 SHALL verify: stop after 2 RUN edges, hold PAUSE 10 cycles, then start -> tick arrives exactly 2 RUN edges after resume; count unchanged during PAUSE.
REQ-040 SHALL verify: in PAUSE, load with load_val=12, then dir=0 and start -> count=9 after load; ticks give 8,7,...,0, then 9 with wrap=1.
REQ-041 SHALL verify: clear and start asserted together in RUN with count=5 -> state=IDLE, count=0, no tick; load asserted in RUN is ignored.
REQ-042 SHALL verify: rst asserted while prescaler=3 in RUN -> all outputs 0 on the next cycle, and the following start gives its first tick 4 edges later.
